// File: rtl/alib_range_image_pkg.sv
// alib_range_image_pkg
// Shared definitions for the range-image writer: the controller state
// encoding, default image geometry and pixel width, and the range value
// that marks a point with no return.
package alib_range_image_pkg;

  // Default image geometry: laser channels x azimuth bins
  localparam int RI_ROWS    = 64;
  localparam int RI_COLS    = 2048;
  localparam int RI_RANGE_W = 16;

  // A range of zero means the laser saw nothing. A stored zero also means
  // the pixel has not been written yet this frame.
  localparam int RANGE_NONE = 0;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } ri_state_t;

endpackage

// File: rtl/alib_ri_rmw_pipe.sv
// alib_ri_rmw_pipe
// Two-stage read-modify-write pipeline that keeps the nearest return per
// pixel. S1 holds the accepted point and presents its address to the RAM
// read port. S2 holds the point while the registered RAM data arrives,
// compares against it, and issues the write.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   acc_valid            a point is accepted this cycle (already bounds-checked)
//   acc_addr, acc_range  linear pixel address and range of that point
//   ram_raddr            read address to the RAM (driven from S1)
//   ram_rdata            registered RAM read data for the S1 address
//   wr_en, wr_addr,      write request from S2 (combinational from S2,
//   wr_data              the forwarding register and ram_rdata)
module alib_ri_rmw_pipe
  import alib_range_image_pkg::*;
#(
  parameter int ADDR_W  = 17,
  parameter int RANGE_W = RI_RANGE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               acc_valid,
  input  logic [ADDR_W-1:0]  acc_addr,
  input  logic [RANGE_W-1:0] acc_range,
  output logic [ADDR_W-1:0]  ram_raddr,
  input  logic [RANGE_W-1:0] ram_rdata,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [RANGE_W-1:0] wr_data
);

  logic               s1_valid;
  logic [ADDR_W-1:0]  s1_addr;
  logic [RANGE_W-1:0] s1_range;
  logic               s2_valid;
  logic [ADDR_W-1:0]  s2_addr;
  logic [RANGE_W-1:0] s2_range;
  logic               last_we;
  logic [ADDR_W-1:0]  last_waddr;
  logic [RANGE_W-1:0] last_wdata;
  logic [RANGE_W-1:0] stored;

  // Pipeline registers plus a one-deep record of the previous write. The
  // RAM reads old data when a read and write hit the same address on the
  // same edge, so that record supplies the value the RAM missed.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_addr    <= '0;
      s1_range   <= '0;
      s2_valid   <= 1'b0;
      s2_addr    <= '0;
      s2_range   <= '0;
      last_we    <= 1'b0;
      last_waddr <= '0;
      last_wdata <= '0;
    end else begin
      s1_valid   <= acc_valid;
      s1_addr    <= acc_addr;
      s1_range   <= acc_range;
      s2_valid   <= s1_valid;
      s2_addr    <= s1_addr;
      s2_range   <= s1_range;
      last_we    <= wr_en;
      last_waddr <= wr_addr;
      last_wdata <= wr_data;
    end
  end

  assign ram_raddr = s1_addr;

  // Keep the nearer return. An empty pixel (stored zero) always takes the
  // new point.
  always_comb begin
    stored = ram_rdata;
    if (last_we && (last_waddr == s2_addr))
      stored = last_wdata;
    wr_en   = s2_valid &&
              ((stored == RANGE_W'(RANGE_NONE)) || (s2_range < stored));
    wr_addr = s2_addr;
    wr_data = s2_range;
  end

endmodule

// File: rtl/alib_range_image_writer.sv
// alib_range_image_writer
// Projects a stream of LiDAR points (row, column, range) into a
// simple-dual-port range-image RAM, keeping the nearest return per pixel.
// On frame_start the image is cleared one address per cycle. Points are
// then accepted at one per cycle until frame_end, and the pipeline is
// drained before done is pulsed.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   frame_start, frame_end     frame control pulses
//   pt_valid/pt_ready          point handshake; pt_row/pt_col/pt_range payload
//   busy                       controller not idle
//   done                       one-cycle pulse when the frame is fully written
//   drop_cnt                   saturating count of points rejected this frame
//   ram_en                     RAM enable
//   ram_we/ram_waddr/ram_wdata RAM write port
//   ram_raddr/ram_rdata        RAM read port (data one cycle after address)
module alib_range_image_writer
  import alib_range_image_pkg::*;
#(
  parameter int ROWS    = RI_ROWS,
  parameter int COLS    = RI_COLS,
  parameter int RANGE_W = RI_RANGE_W,
  parameter int ADDR_W  = $clog2(ROWS * COLS),
  parameter int ROW_W   = $clog2(ROWS),
  parameter int COL_W   = $clog2(COLS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               pt_valid,
  output logic               pt_ready,
  input  logic [ROW_W-1:0]   pt_row,
  input  logic [COL_W-1:0]   pt_col,
  input  logic [RANGE_W-1:0] pt_range,
  output logic               busy,
  output logic               done,
  output logic [15:0]        drop_cnt,
  output logic               ram_en,
  output logic [ADDR_W-1:0]  ram_waddr,
  output logic [RANGE_W-1:0] ram_wdata,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_raddr,
  input  logic [RANGE_W-1:0] ram_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS * COLS - 1);
  // One extra bit so the limits themselves are representable, which lets a
  // port wider than the image report an out-of-bounds coordinate.
  localparam logic [ROW_W:0]    ROW_LIMIT = (ROW_W + 1)'(ROWS);
  localparam logic [COL_W:0]    COL_LIMIT = (COL_W + 1)'(COLS);

  ri_state_t          state;
  logic [ADDR_W-1:0]  clear_addr;
  logic               clear_we;
  logic               drain_cnt;

  logic               handshake;
  logic               reject;
  logic               drop;
  logic               acc_valid;
  logic [ADDR_W-1:0]  pt_addr;
  logic               pipe_we;
  logic [ADDR_W-1:0]  pipe_waddr;
  logic [RANGE_W-1:0] pipe_wdata;

  assign handshake = pt_valid & pt_ready;
  assign reject    = ({1'b0, pt_row} >= ROW_LIMIT) ||
                     ({1'b0, pt_col} >= COL_LIMIT) ||
                     (pt_range == RANGE_W'(RANGE_NONE));
  assign drop      = handshake & reject;
  assign acc_valid = handshake & ~reject;
  assign pt_addr   = ADDR_W'(pt_row) * ADDR_W'(COLS) + ADDR_W'(pt_col);
  assign busy      = (state != IDLE);

  // Frame controller. All handshake and status outputs are registered here;
  // the clear write stream is a registered address walk that hands over to
  // RUN right after the last address is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      clear_addr <= '0;
      clear_we   <= 1'b0;
      drain_cnt  <= 1'b0;
      pt_ready   <= 1'b0;
      done       <= 1'b0;
      drop_cnt   <= '0;
      ram_en     <= 1'b0;
    end else begin
      ram_en <= 1'b1;
      done   <= 1'b0;
      if (drop && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
      case (state)
        IDLE: begin
          if (frame_start) begin
            state      <= CLEAR;
            clear_we   <= 1'b1;
            clear_addr <= '0;
            drop_cnt   <= '0;
          end
        end
        CLEAR: begin
          if (clear_addr == LAST_ADDR) begin
            state    <= RUN;
            clear_we <= 1'b0;
            pt_ready <= 1'b1;
          end else begin
            clear_addr <= clear_addr + 1'b1;
          end
        end
        RUN: begin
          if (frame_end) begin
            state     <= DRAIN;
            pt_ready  <= 1'b0;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          // Two cycles let the last accepted point pass S1 and S2.
          if (drain_cnt) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  alib_ri_rmw_pipe #(
    .ADDR_W  (ADDR_W),
    .RANGE_W (RANGE_W)
  ) u_rmw_pipe (
    .clk       (clk),
    .rst       (rst),
    .acc_valid (acc_valid),
    .acc_addr  (pt_addr),
    .acc_range (pt_range),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .wr_en     (pipe_we),
    .wr_addr   (pipe_waddr),
    .wr_data   (pipe_wdata)
  );

  // The clear stream and the pipeline never write in the same cycle: the
  // pipeline is empty throughout CLEAR.
  assign ram_we    = clear_we | pipe_we;
  assign ram_waddr = clear_we ? clear_addr : pipe_waddr;
  assign ram_wdata = clear_we ? RANGE_W'(RANGE_NONE) : pipe_wdata;

endmodule

// File: tb/tb_alib_range_image_writer.sv
// tb_alib_range_image_writer
// Directed bench for the range-image writer on a 4x8 image. A behavioural
// simple-dual-port RAM (read-first, registered read, gated by ram_en)
// closes the loop, and every write is logged for comparison against
// hand-computed expectations.
module tb_alib_range_image_writer;

  localparam int ROWS    = 4;
  localparam int COLS    = 8;
  localparam int RANGE_W = 16;
  localparam int ADDR_W  = 5;
  localparam int ROW_W   = 3;
  localparam int COL_W   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               frame_start;
  logic               frame_end;
  logic               pt_valid;
  logic               pt_ready;
  logic [ROW_W-1:0]   pt_row;
  logic [COL_W-1:0]   pt_col;
  logic [RANGE_W-1:0] pt_range;
  logic               busy;
  logic               done;
  logic [15:0]        drop_cnt;
  logic               ram_en;
  logic [ADDR_W-1:0]  ram_waddr;
  logic [RANGE_W-1:0] ram_wdata;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_raddr;
  logic [RANGE_W-1:0] ram_rdata = '0;

  logic [RANGE_W-1:0] mem [ROWS*COLS];
  logic [ADDR_W-1:0]  wlog_addr [$];
  logic [RANGE_W-1:0] wlog_data [$];
  int                 done_seen = 0;
  int                 n_compared = 0;
  int                 n_mismatched = 0;

  typedef struct {
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [RANGE_W-1:0] rng;
    logic               exp_we;
    logic [ADDR_W-1:0]  exp_addr;
    logic [RANGE_W-1:0] exp_data;
    logic [15:0]        exp_drop;
  } vec_t;

  vec_t vecs [10];

  alib_range_image_writer #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .RANGE_W (RANGE_W),
    .ADDR_W  (ADDR_W),
    .ROW_W   (ROW_W),
    .COL_W   (COL_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .pt_valid    (pt_valid),
    .pt_ready    (pt_ready),
    .pt_row      (pt_row),
    .pt_col      (pt_col),
    .pt_range    (pt_range),
    .busy        (busy),
    .done        (done),
    .drop_cnt    (drop_cnt),
    .ram_en      (ram_en),
    .ram_waddr   (ram_waddr),
    .ram_wdata   (ram_wdata),
    .ram_we      (ram_we),
    .ram_raddr   (ram_raddr),
    .ram_rdata   (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: read-first on a same-address collision, output zero
  // and ignore writes while disabled.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we)
        mem[ram_waddr] <= ram_wdata;
      ram_rdata <= mem[ram_raddr];
    end else begin
      ram_rdata <= '0;
    end
  end

  // Write and done monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && ram_we) begin
      wlog_addr.push_back(ram_waddr);
      wlog_data.push_back(ram_wdata);
    end
    if (done === 1'b1)
      done_seen = done_seen + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                               input logic [RANGE_W-1:0] rng, input logic fe);
    pt_valid  = 1'b1;
    pt_row    = row;
    pt_col    = col;
    pt_range  = rng;
    frame_end = fe;
    @(negedge clk);
    pt_valid  = 1'b0;
    pt_row    = '0;
    pt_col    = '0;
    pt_range  = '0;
    frame_end = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pt_ready"},  int'(pt_ready),  0);
    checkOutput({tag, "_busy"},      int'(busy),      0);
    checkOutput({tag, "_done"},      int'(done),      0);
    checkOutput({tag, "_ram_we"},    int'(ram_we),    0);
    checkOutput({tag, "_ram_en"},    int'(ram_en),    0);
    checkOutput({tag, "_ram_waddr"}, int'(ram_waddr), 0);
    checkOutput({tag, "_ram_raddr"}, int'(ram_raddr), 0);
    checkOutput({tag, "_ram_wdata"}, int'(ram_wdata), 0);
    checkOutput({tag, "_drop_cnt"},  int'(drop_cnt),  0);
  endtask

  task automatic clearLog();
    wlog_addr.delete();
    wlog_data.delete();
  endtask

  initial begin
    int bad;

    // Vectors applied one at a time on a freshly cleared image, after the
    // forwarding sequences have left 10=300 and 19=300.
    vecs[0] = '{3'd1, 4'd2, 16'd400,   1'b0, 5'd0,  16'd0,   16'd0};
    vecs[1] = '{3'd1, 4'd2, 16'd250,   1'b1, 5'd10, 16'd250, 16'd0};
    vecs[2] = '{3'd0, 4'd0, 16'd7,     1'b1, 5'd0,  16'd7,   16'd0};
    vecs[3] = '{3'd4, 4'd0, 16'd100,   1'b0, 5'd0,  16'd0,   16'd1};
    vecs[4] = '{3'd0, 4'd8, 16'd100,   1'b0, 5'd0,  16'd0,   16'd2};
    vecs[5] = '{3'd0, 4'd0, 16'd0,     1'b0, 5'd0,  16'd0,   16'd3};
    vecs[6] = '{3'd0, 4'd0, 16'd7,     1'b0, 5'd0,  16'd0,   16'd3};
    vecs[7] = '{3'd0, 4'd0, 16'd6,     1'b1, 5'd0,  16'd6,   16'd3};
    vecs[8] = '{3'd3, 4'd0, 16'd1,     1'b1, 5'd24, 16'd1,   16'd3};
    vecs[9] = '{3'd2, 4'd3, 16'd299,   1'b1, 5'd19, 16'd299, 16'd3};

    rst         = 1'b1;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    pt_valid    = 1'b0;
    pt_row      = '0;
    pt_col      = '0;
    pt_range    = '0;

    // Reset state, then ram_en rising one cycle after release.
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ram_en_after_reset", int'(ram_en), 1);

    // Abort a clear at address 12 with reset.
    frame_start = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      frame_start = 1'b0;
    end
    checkOutput("abort_clear_addr", int'(ram_waddr), 12);
    rst = 1'b1;
    @(negedge clk);
    checkResetValues("abort");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_no_done", done_seen, 0);

    // Full clear with a stray frame_end in the middle.
    clearLog();
    bad = 0;
    frame_start = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      frame_start = 1'b0;
      frame_end   = (k == 5);
      if (!(ram_we === 1'b1 && ram_waddr == ADDR_W'(k - 1) && ram_wdata == '0 &&
            ram_en === 1'b1 && pt_ready === 1'b0 && busy === 1'b1))
        bad++;
    end
    frame_end = 1'b0;
    checkOutput("clear_bad_cycles", bad, 0);
    @(negedge clk);
    checkOutput("clear_ready_cycle33", int'(pt_ready), 1);
    checkOutput("clear_we_cycle33", int'(ram_we), 0);
    checkOutput("clear_write_count", wlog_addr.size(), 32);

    // Back-to-back same pixel, nearer second: both write.
    clearLog();
    pt_valid = 1'b1; pt_row = 3'd1; pt_col = 4'd2; pt_range = 16'd500;
    @(negedge clk);
    pt_range = 16'd300;
    @(negedge clk);
    pt_valid = 1'b0; pt_row = '0; pt_col = '0; pt_range = '0;
    repeat (3) @(negedge clk);
    checkOutput("b2b_write_count", wlog_addr.size(), 2);
    if (wlog_addr.size() == 2) begin
      checkOutput("b2b_addr0", int'(wlog_addr[0]), 10);
      checkOutput("b2b_data0", int'(wlog_data[0]), 500);
      checkOutput("b2b_addr1", int'(wlog_addr[1]), 10);
      checkOutput("b2b_data1", int'(wlog_data[1]), 300);
    end

    // Back-to-back same pixel, farther second: only forwarding suppresses it.
    clearLog();
    pt_valid = 1'b1; pt_row = 3'd2; pt_col = 4'd3; pt_range = 16'd300;
    @(negedge clk);
    pt_range = 16'd500;
    @(negedge clk);
    pt_valid = 1'b0; pt_row = '0; pt_col = '0; pt_range = '0;
    repeat (3) @(negedge clk);
    checkOutput("fwd_write_count", wlog_addr.size(), 1);
    if (wlog_addr.size() == 1) begin
      checkOutput("fwd_addr", int'(wlog_addr[0]), 19);
      checkOutput("fwd_data", int'(wlog_data[0]), 300);
    end

    // Table of isolated points.
    for (int i = 0; i < 10; i++) begin
      clearLog();
      applyStimulus(vecs[i].row, vecs[i].col, vecs[i].rng, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput($sformatf("vec%0d_write_count", i), wlog_addr.size(), int'(vecs[i].exp_we));
      if (vecs[i].exp_we && wlog_addr.size() == 1) begin
        checkOutput($sformatf("vec%0d_addr", i), int'(wlog_addr[0]), int'(vecs[i].exp_addr));
        checkOutput($sformatf("vec%0d_data", i), int'(wlog_data[0]), int'(vecs[i].exp_data));
      end
      checkOutput($sformatf("vec%0d_drop_cnt", i), int'(drop_cnt), int'(vecs[i].exp_drop));
    end

    // frame_start while running must not restart the clear.
    clearLog();
    bad = 0;
    frame_start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (!(busy === 1'b1 && pt_ready === 1'b1 && ram_we === 1'b0))
        bad++;
    end
    checkOutput("run_frame_start_bad_cycles", bad, 0);
    checkOutput("run_frame_start_writes", wlog_addr.size(), 0);

    // Last point accepted together with frame_end, then drain and done.
    clearLog();
    applyStimulus(3'd3, 4'd7, 16'd65535, 1'b1);
    checkOutput("fe_ready_low", int'(pt_ready), 0);
    checkOutput("fe_busy_drain1", int'(busy), 1);
    checkOutput("fe_done_drain1", int'(done), 0);
    @(negedge clk);
    checkOutput("fe_we", int'(ram_we), 1);
    checkOutput("fe_waddr", int'(ram_waddr), 31);
    checkOutput("fe_wdata", int'(ram_wdata), 65535);
    checkOutput("fe_done_drain2", int'(done), 0);
    @(negedge clk);
    checkOutput("fe_done_pulse", int'(done), 1);
    checkOutput("fe_busy_with_done", int'(busy), 0);
    @(negedge clk);
    checkOutput("fe_done_one_cycle", int'(done), 0);
    checkOutput("fe_drop_cnt_held", int'(drop_cnt), 3);
    checkOutput("fe_write_count", wlog_addr.size(), 1);
    checkOutput("done_pulse_total", done_seen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
